mmio_fifo_port: RTL and testbench

Memory-mapped dual-FIFO peripheral that is the responder on the processor's memory bus (ADDR, DOUT, W in; read data back toward DIN). The processor pushes words into a TX FIFO drained by a device-side valid/ready consumer. A device-side producer fills an RX FIFO that the processor reads and pops. Read data is returned with synchronous-memory timing, so it drops into the processor's existing memory wait cycles.

---
 rtl/mmio_fifo_port.sv | 150 +++++++++++++++
 tb/tb_mmio_fifo_port.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_port.sv
// Memory-mapped dual FIFO port: processor-side TX push / RX pop, device-side valid/ready streams.
// Optional sticky overflow flags are built only when MMIO_FIFO_OVF_EN is defined.
module mmio_fifo_port #(
  parameter logic [15:0] BASE  = 16'h4000,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] rdata,
  output logic        hit,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [15:0]   r_tx_mem [DEPTH];
  logic [15:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [AW:0]   r_tx_count, r_rx_count;
  logic [15:0]   r_rdata;
  logic          r_hit;

  logic          w_sel, w_wr;
  logic [1:0]    w_off;
  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic          w_tx_push_req, w_tx_push, w_tx_pop;
  logic          w_rx_push_req, w_rx_push, w_rx_pop;
  logic          w_tx_ovf, w_rx_ovf;
  logic [6:0]    w_tx_cnt7, w_rx_cnt7;
  logic [15:0]   w_rd;

  assign w_sel = (ADDR[15:2] == BASE[15:2]);
  assign w_off = ADDR[1:0];
  assign w_wr  = W & w_sel;

  assign w_tx_full  = (r_tx_count == FullCnt);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == FullCnt);
  assign w_rx_empty = (r_rx_count == '0);

  assign tx_valid = ~w_tx_empty;
  assign tx_data  = r_tx_mem[r_tx_rptr];
  assign rx_ready = ~w_rx_full;

  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign w_tx_pop      = tx_valid & tx_ready;
  assign w_tx_push_req = w_wr & (w_off == 2'd0);
  assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);

  assign w_rx_pop      = w_wr & (w_off == 2'd1) & ~w_rx_empty;
  assign w_rx_push_req = rx_valid & rx_ready;
  assign w_rx_push     = w_rx_push_req & (~w_rx_full | w_rx_pop);

  always_ff @(posedge Clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= DOUT;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
    end
  end

`ifdef MMIO_FIFO_OVF_EN
  logic r_tx_ovf, r_rx_ovf;
  logic w_ovf_clr, w_tx_drop, w_rx_drop;

  assign w_ovf_clr = w_wr & (w_off == 2'd2);
  assign w_tx_drop = w_tx_push_req & w_tx_full & ~w_tx_pop;
  assign w_rx_drop = w_rx_push_req & w_rx_full & ~w_rx_pop;

  // A new overflow takes priority over a same-cycle clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_tx_drop)      r_tx_ovf <= 1'b1;
      else if (w_ovf_clr) r_tx_ovf <= 1'b0;
      if (w_rx_drop)      r_rx_ovf <= 1'b1;
      else if (w_ovf_clr) r_rx_ovf <= 1'b0;
    end
  end

  assign w_tx_ovf = r_tx_ovf;
  assign w_rx_ovf = r_rx_ovf;
`else
  assign w_tx_ovf = 1'b0;
  assign w_rx_ovf = 1'b0;
`endif

  assign w_tx_cnt7 = 7'(r_tx_count);
  assign w_rx_cnt7 = 7'(r_rx_count);

  always_comb begin
    w_rd = 16'h0000;
    if (w_sel) begin
      case (w_off)
        2'd0:    w_rd = 16'h0000;
        2'd1:    w_rd = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rptr];
        2'd2:    w_rd = {11'b0, w_rx_ovf, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
        default: w_rd = {w_tx_ovf, w_rx_cnt7, 1'b0, w_tx_cnt7};
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_rdata <= w_rd;
      r_hit   <= w_sel;
    end
  end

  assign rdata = r_rdata;
  assign hit   = r_hit;

endmodule

// File: tb/tb_mmio_fifo_port.sv
// Directed self-checking bench for mmio_fifo_port (DEPTH=8, BASE=16'h4000).
module tb_mmio_fifo_port;

  localparam logic [15:0] Base = 16'h4000;

  logic        clk, resetn;
  logic [15:0] addr, dout, rdata, tx_data, rx_data;
  logic        w, hit, tx_valid, tx_ready, rx_valid, rx_ready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] d;
  logic        h;
  logic [15:0] exp_ovf;

  mmio_fifo_port #(
    .BASE  (Base),
    .DEPTH (8),
    .AW    (3)
  ) u_dut (
    .Clock    (clk),
    .Resetn   (resetn),
    .ADDR     (addr),
    .DOUT     (dout),
    .W        (w),
    .rdata    (rdata),
    .hit      (hit),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] data, output logic hv);
    addr = a;
    w    = 1'b0;
    tick();
    data = rdata;
    hv   = hit;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] data);
    addr = a;
    dout = data;
    w    = 1'b1;
    tick();
    w    = 1'b0;
    addr = 16'h0000;
  endtask

  initial begin
    resetn = 1'b0; addr = '0; dout = '0; w = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // Reset mid-traffic
    wr(Base, 16'h1234);
    rx_data = 16'hABCD; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rd(Base + 16'd3, d, h);
    check_eq("pre_reset_counts", d, 16'h0101);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    check_eq("rst_rx_ready", {15'b0, rx_ready}, 16'h0001);
    check_eq("rst_rdata", rdata, 16'h0000);
    check_eq("rst_hit", {15'b0, hit}, 16'h0000);
    tick();
    resetn = 1'b1;
    rd(Base + 16'd2, d, h);
    check_eq("rst_status", d, 16'h0005);  // tx_empty (bit 2) and rx_empty (bit 0)
    rd(Base + 16'd3, d, h);
    check_eq("rst_counts", d, 16'h0000);

    // Status read in the same cycle as a device push shows the pre-push state
    addr = Base + 16'd2; rx_data = 16'h7777; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_eq("raw_before", rdata, 16'h0005);
    rd(Base + 16'd2, d, h);
    check_eq("raw_after", d, 16'h0004);
    wr(Base + 16'd1, 16'h0);

    // TX ordering
    wr(Base, 16'h1111);
    check_eq("tx_valid_1", {15'b0, tx_valid}, 16'h0001);
    wr(Base, 16'h2222);
    wr(Base, 16'h3333);
    tx_ready = 1'b1;
    check_eq("tx_head_0", tx_data, 16'h1111);
    tick();
    check_eq("tx_head_1", tx_data, 16'h2222);
    tick();
    check_eq("tx_head_2", tx_data, 16'h3333);
    tick();
    check_eq("tx_drained", {15'b0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    // RX read / pop
    rx_valid = 1'b1; rx_data = 16'hBEEF;
    tick();
    rx_data = 16'hCAFE;
    tick();
    rx_valid = 1'b0;
    rd(Base + 16'd1, d, h);
    check_eq("rx_head_beef", d, 16'hBEEF);
    check_eq("rx_hit", {15'b0, h}, 16'h0001);
    wr(Base + 16'd1, 16'hFFFF);
    rd(Base + 16'd1, d, h);
    check_eq("rx_head_cafe", d, 16'hCAFE);
    check_eq("rx_hit2", {15'b0, h}, 16'h0001);
    wr(Base + 16'd1, 16'h0);
    rd(Base + 16'd1, d, h);
    check_eq("rx_empty_read", d, 16'h0000);

    // TX full and overflow
`ifdef MMIO_FIFO_OVF_EN
    exp_ovf = 16'h8008;
`else
    exp_ovf = 16'h0008;
`endif
    for (int i = 0; i < 9; i++) wr(Base, 16'hA000 + 16'(i));
    check_eq("full_head", tx_data, 16'hA000);
    rd(Base + 16'd3, d, h);
    check_eq("ovf_counts", d, exp_ovf);
    rd(Base + 16'd2, d, h);
    check_eq("full_status", d, 16'h0009);
    wr(Base + 16'd2, 16'h0);
    rd(Base + 16'd3, d, h);
    check_eq("ovf_cleared", d, 16'h0008);

    // Push and pop together while full
    addr = Base; dout = 16'hB0B0; w = 1'b1; tx_ready = 1'b1;
    tick();
    w = 1'b0; tx_ready = 1'b0;
    rd(Base + 16'd3, d, h);
    check_eq("simul_counts", d, 16'h0008);
    tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check_eq("simul_drain", tx_data, 16'hA000 + 16'(i));
      tick();
    end
    check_eq("simul_new_8th", tx_data, 16'hB0B0);
    tick();
    check_eq("simul_empty", {15'b0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    // RX fill, wrap and repeat reads
    for (int k = 0; k < 8; k++) begin
      rx_valid = 1'b1; rx_data = 16'h5000 + 16'(k);
      tick();
    end
    check_eq("rx_full_ready", {15'b0, rx_ready}, 16'h0000);
    rx_data = 16'hDEAD;
    tick();
    rx_valid = 1'b0;
    rd(Base + 16'd3, d, h);
    check_eq("rx_full_counts", d, 16'h0800);
    for (int k = 0; k < 8; k++) begin
      rd(Base + 16'd1, d, h);
      check_eq("rx_order", d, 16'h5000 + 16'(k));
      wr(Base + 16'd1, 16'h0);
    end
    for (int k = 8; k < 20; k++) begin
      rx_valid = 1'b1; rx_data = 16'h5000 + 16'(k);
      tick();
      rx_valid = 1'b0;
      rd(Base + 16'd1, d, h);
      check_eq("rx_wrap_a", d, 16'h5000 + 16'(k));
      rd(Base + 16'd1, d, h);
      check_eq("rx_wrap_b", d, 16'h5000 + 16'(k));
      wr(Base + 16'd1, 16'h0);
    end
    rd(Base + 16'd3, d, h);
    check_eq("rx_final_counts", d, 16'h0000);
    rd(16'h0000, d, h);
    check_eq("nosel_rdata", d, 16'h0000);
    check_eq("nosel_hit", {15'b0, h}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
